// File: rtl/mrt_pkg.sv
// Shared types for the minroot engine: multiplier command encoding and
// exponentiation sequencer states.
package mrt_pkg;

  localparam int MaxExpoBits = 254;
  localparam int MsbBits     = $clog2(MaxExpoBits);

  typedef enum logic {
    Sqr = 1'b0,
    Mul = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    XOut = 2'd0,
    X1   = 2'd1,
    XTmp = 2'd2
  } x_vars_e;

  typedef struct packed {
    op_e     op;
    x_vars_e out;
    x_vars_e a;
    x_vars_e b;
  } mul_cmd_t;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StScan = 3'd1,
    StSqr  = 3'd2,
    StMul  = 3'd3,
    StDone = 3'd4
  } seq_state_e;

  // Base and accumulator swap roles every iteration so no copy command is needed.
  function automatic x_vars_e base_var(input logic odd_iter);
    return odd_iter ? XTmp : X1;
  endfunction

  function automatic x_vars_e acc_var(input logic odd_iter);
    return odd_iter ? X1 : XTmp;
  endfunction

endpackage

// File: rtl/mrt_expo_seq_msb_find.sv
// Priority encoder: index of the highest set bit of vec, plus an all-zero flag.
import mrt_pkg::*;

module mrt_msb_find #(
  parameter int Width   = 254,
  parameter int IdxBits = $clog2(Width)
) (
  input  logic [Width-1:0]   vec,
  output logic [IdxBits-1:0] idx,
  output logic               zero
);

  always_comb begin
    idx  = '0;
    zero = 1'b1;
    for (int i = 0; i < Width; i++) begin
      if (vec[i]) begin
        idx  = IdxBits'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mrt_expo_seq.sv
// Left-to-right square-and-multiply command sequencer for the modular
// multiplier, repeated over a runtime number of root iterations.
//
// state  | meaning
// IDLE   | waiting for start; rejects expo<2 or iters==0 with err_o
// SCAN   | registers the exponent msb index, primes bit_idx and first
// SQR    | issues Sqr for the current exponent bit
// MUL    | issues Mul when the current exponent bit is set
// DONE   | one-cycle done_o pulse, then back to IDLE
import mrt_pkg::*;

module mrt_expo_seq #(
  parameter int ExpoBits = 254,
  parameter int IterBits = 48,
  parameter int MsbBits  = $clog2(ExpoBits)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [ExpoBits-1:0] expo_i,
  input  logic [IterBits-1:0] iters_i,
  output logic                busy_o,
  output logic                cmd_valid_o,
  input  logic                cmd_ready_i,
  output op_e                 cmd_op_o,
  output x_vars_e             cmd_out_o,
  output x_vars_e             cmd_a_o,
  output x_vars_e             cmd_b_o,
  output logic                cmd_last_o,
  output logic [IterBits-1:0] iter_o,
  output logic                done_o,
  output logic                err_o
);

  seq_state_e          state_q, state_d;
  logic [ExpoBits-1:0] expo_q, expo_d;
  logic [IterBits-1:0] iters_q, iters_d;
  logic [IterBits-1:0] iter_q, iter_d;
  logic [MsbBits-1:0]  msb_q, msb_d;
  logic [MsbBits-1:0]  bit_idx_q, bit_idx_d;
  logic                first_q, first_d;
  logic                err_q, err_d;

  logic [MsbBits-1:0]  msb_idx;
  logic                msb_zero;
  logic                hs;
  logic                cur_bit;
  logic                last_iter;
  logic                bit_end;
  logic                is_last;
  mul_cmd_t            cmd;
  x_vars_e             base_v;
  x_vars_e             acc_v;

  mrt_msb_find #(
    .Width  (ExpoBits),
    .IdxBits(MsbBits)
  ) u_msb_find (
    .vec (expo_q),
    .idx (msb_idx),
    .zero(msb_zero)
  );

  assign cur_bit   = expo_q[bit_idx_q];
  assign last_iter = (iter_q == iters_q - IterBits'(1));
  assign hs        = cmd_valid_o && cmd_ready_i;
  // A bit is finished by Sqr when its exponent bit is clear, otherwise by Mul.
  assign bit_end   = hs && ((state_q == StSqr && !cur_bit) || state_q == StMul);
  assign is_last   = last_iter && (bit_idx_q == '0) &&
                     ((state_q == StSqr && !cur_bit) || state_q == StMul);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      expo_q    <= '0;
      iters_q   <= '0;
      iter_q    <= '0;
      msb_q     <= '0;
      bit_idx_q <= '0;
      first_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      expo_q    <= expo_d;
      iters_q   <= iters_d;
      iter_q    <= iter_d;
      msb_q     <= msb_d;
      bit_idx_q <= bit_idx_d;
      first_q   <= first_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    expo_d    = expo_q;
    iters_d   = iters_q;
    iter_d    = iter_q;
    msb_d     = msb_q;
    bit_idx_d = bit_idx_q;
    first_d   = first_q;
    err_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          expo_d  = expo_i;
          iters_d = iters_i;
          iter_d  = '0;
          if (expo_i[ExpoBits-1:1] == '0 || iters_i == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = StScan;
          end
        end
      end
      StScan: begin
        msb_d     = msb_idx;
        bit_idx_d = msb_idx - MsbBits'(1);
        first_d   = 1'b1;
        state_d   = msb_zero ? StIdle : StSqr;
      end
      StSqr: begin
        if (hs) begin
          first_d = 1'b0;
          if (cur_bit) state_d = StMul;
        end
      end
      StMul: ;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (bit_end) begin
      if (bit_idx_q != '0) begin
        bit_idx_d = bit_idx_q - MsbBits'(1);
        state_d   = StSqr;
      end else if (!last_iter) begin
        iter_d    = iter_q + IterBits'(1);
        bit_idx_d = msb_q - MsbBits'(1);
        first_d   = 1'b1;
        state_d   = StSqr;
      end else begin
        state_d = StDone;
      end
    end
  end

  assign base_v = base_var(iter_q[0]);
  assign acc_v  = acc_var(iter_q[0]);

  always_comb begin
    cmd.op      = Sqr;
    cmd.out     = XOut;
    cmd.a       = XOut;
    cmd.b       = XOut;
    cmd_valid_o = 1'b0;

    case (state_q)
      StSqr: begin
        cmd_valid_o = 1'b1;
        cmd.op      = Sqr;
        cmd.out     = acc_v;
        cmd.a       = first_q ? base_v : acc_v;
        cmd.b       = first_q ? base_v : acc_v;
      end
      StMul: begin
        cmd_valid_o = 1'b1;
        cmd.op      = Mul;
        cmd.out     = acc_v;
        cmd.a       = acc_v;
        cmd.b       = base_v;
      end
      default: ;
    endcase

    if (is_last) cmd.out = XOut;
  end

  assign cmd_op_o   = cmd.op;
  assign cmd_out_o  = cmd.out;
  assign cmd_a_o    = cmd.a;
  assign cmd_b_o    = cmd.b;
  assign cmd_last_o = is_last;
  assign iter_o     = iter_q;
  assign busy_o     = (state_q == StScan) || (state_q == StSqr) || (state_q == StMul);
  assign done_o     = (state_q == StDone);
  assign err_o      = err_q;

endmodule

// File: tb/tb_mrt_expo_seq.sv
// Self-checking bench for mrt_expo_seq: a square-and-multiply reference model
// fills a command queue that a handshake monitor drains and compares.
module tb_mrt_expo_seq;
  import mrt_pkg::*;

  localparam int EB = 254;
  localparam int IB = 48;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          start   = 1'b0;
  logic [EB-1:0] expo    = '0;
  logic [IB-1:0] iters   = '0;
  logic          ready   = 1'b0;
  logic          busy, valid, last, done, err;
  op_e           op;
  x_vars_e       out_v, a_v, b_v;
  logic [IB-1:0] iter;

  mrt_expo_seq #(.ExpoBits(EB), .IterBits(IB)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .expo_i     (expo),
    .iters_i    (iters),
    .busy_o     (busy),
    .cmd_valid_o(valid),
    .cmd_ready_i(ready),
    .cmd_op_o   (op),
    .cmd_out_o  (out_v),
    .cmd_a_o    (a_v),
    .cmd_b_o    (b_v),
    .cmd_last_o (last),
    .iter_o     (iter),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    op_e           op;
    x_vars_e       out;
    x_vars_e       a;
    x_vars_e       b;
    logic          last;
    logic [IB-1:0] iter;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_hs_cyc = 0;
  int   hs_count = 0;
  bit   mon_en = 0;
  int   ready_mode = 1;

  always @(posedge clk) cyc <= cyc + 1;

  // 0: ready low, 1: ready high, 2: random with 70% stall
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       ready = 1'b0;
      1:       ready = 1'b1;
      default: ready = ($urandom_range(0, 99) >= 70);
    endcase
  end

  logic    prev_stall = 1'b0;
  logic    prev_cont  = 1'b0;
  op_e     p_op;
  x_vars_e p_out, p_a, p_b;
  logic    p_last;
  exp_t    e_mon;

  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (err !== 1'b0) begin
        bad++;
        $display("FAIL err_during_run: err_o=%b required 0", err);
      end
      if (prev_stall) begin
        total++;
        if (valid !== 1'b1 || op !== p_op || out_v !== p_out || a_v !== p_a ||
            b_v !== p_b || last !== p_last) begin
          bad++;
          $display("FAIL stall_hold: valid=%b op=%s out=%s a=%s b=%s last=%b, required held op=%s out=%s a=%s b=%s last=%b",
                   valid, op.name(), out_v.name(), a_v.name(), b_v.name(), last,
                   p_op.name(), p_out.name(), p_a.name(), p_b.name(), p_last);
        end
      end
      if (prev_cont) begin
        total++;
        if (valid !== 1'b1) begin
          bad++;
          $display("FAIL bubble: cmd_valid_o=%b after non-final handshake, required 1", valid);
        end
      end
      prev_stall = valid && !ready;
      prev_cont  = valid && ready && !last;
      p_op = op; p_out = out_v; p_a = a_v; p_b = b_v; p_last = last;
      if (valid === 1'b1 && ready === 1'b1) begin
        hs_count++;
        last_hs_cyc = cyc;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_cmd: op=%s out=%s with empty scoreboard", op.name(), out_v.name());
        end else begin
          e_mon = q.pop_front();
          if (op !== e_mon.op || out_v !== e_mon.out || a_v !== e_mon.a || b_v !== e_mon.b ||
              last !== e_mon.last || iter !== e_mon.iter) begin
            bad++;
            $display("FAIL cmd#%0d: got op=%s out=%s a=%s b=%s last=%b iter=%0d, required op=%s out=%s a=%s b=%s last=%b iter=%0d",
                     hs_count, op.name(), out_v.name(), a_v.name(), b_v.name(), last, iter,
                     e_mon.op.name(), e_mon.out.name(), e_mon.a.name(), e_mon.b.name(),
                     e_mon.last, e_mon.iter);
          end
        end
      end
    end else begin
      prev_stall = 1'b0;
      prev_cont  = 1'b0;
    end
  end

  function automatic exp_t mk(op_e o, x_vars_e d, x_vars_e x, x_vars_e y, int k);
    exp_t r;
    r.op = o; r.out = d; r.a = x; r.b = y; r.last = 1'b0; r.iter = IB'(k);
    return r;
  endfunction

  task automatic push_model(input logic [EB-1:0] e, input int n);
    int      msb = -1;
    x_vars_e bv, av;
    bit      fst;
    exp_t    t;
    for (int i = 0; i < EB; i++) if (e[i]) msb = i;
    for (int k = 0; k < n; k++) begin
      bv  = (k % 2 == 1) ? XTmp : X1;
      av  = (k % 2 == 1) ? X1 : XTmp;
      fst = 1'b1;
      for (int bi = msb - 1; bi >= 0; bi--) begin
        q.push_back(mk(Sqr, av, fst ? bv : av, fst ? bv : av, k));
        fst = 1'b0;
        if (e[bi]) q.push_back(mk(Mul, av, av, bv, k));
      end
    end
    t = q.pop_back();
    t.out  = XOut;
    t.last = 1'b1;
    q.push_back(t);
  endtask

  task automatic run_seq(input logic [EB-1:0] e, input int n, input int budget,
                         input bit poke);
    int exp_n;
    bit done_seen = 0;
    q.delete();
    push_model(e, n);
    exp_n    = q.size();
    hs_count = 0;
    mon_en   = 1;
    @(posedge clk); #1;
    start = 1'b1; expo = e; iters = IB'(n);
    @(posedge clk); #1;
    start = 1'b0; expo = '0; iters = '0;
    total++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL scan_cycle: valid=%b busy=%b, required valid=0 busy=1", valid, busy);
    end
    @(posedge clk); #1;
    total++;
    if (valid !== 1'b1) begin
      bad++;
      $display("FAIL first_valid_latency: valid=%b two cycles after accept, required 1", valid);
    end
    if (poke) begin
      start = 1'b1; expo = EB'(1); iters = IB'(1);
      @(posedge clk); #1;
      start = 1'b0; expo = '0; iters = '0;
    end
    for (int i = 0; i < budget && !done_seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen = 1;
    end
    total++;
    if (!done_seen) begin
      bad++;
      $display("FAIL done_timeout: no done_o within %0d cycles, required done", budget);
    end else begin
      total++;
      if (cyc !== last_hs_cyc + 1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL done_timing: done at cyc=%0d busy=%b, required cyc=%0d busy=0",
                 cyc, busy, last_hs_cyc + 1);
      end
    end
    total++;
    if (hs_count != exp_n || q.size() != 0) begin
      bad++;
      $display("FAIL cmd_count: handshakes=%0d left=%0d, required %0d and 0",
               hs_count, q.size(), exp_n);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse: done=%b busy=%b next cycle, required 0 0", done, busy);
    end
    mon_en = 0;
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if (busy !== 1'b0 || valid !== 1'b0 || op !== Sqr || out_v !== XOut || a_v !== XOut ||
        b_v !== XOut || last !== 1'b0 || iter !== '0 || done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL %s: busy=%b valid=%b op=%s out=%s a=%s b=%s last=%b iter=%0d done=%b err=%b, required all 0 op=Sqr vars=XOut",
               name, busy, valid, op.name(), out_v.name(), a_v.name(), b_v.name(), last,
               iter, done, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_single();
    ready_mode = 1;
    run_seq(EB'(8'h0B), 1, 50, 0);
  endtask

  task automatic test_two_iters();
    ready_mode = 1;
    run_seq(EB'(8'h0B), 2, 80, 0);
  endtask

  task automatic test_errors();
    logic [EB-1:0] ev[3];
    int            nv[3];
    ev[0] = EB'(1);     nv[0] = 1;
    ev[1] = EB'(0);     nv[1] = 1;
    ev[2] = EB'(8'h0B); nv[2] = 0;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      start = 1'b1; expo = ev[t]; iters = IB'(nv[t]);
      @(posedge clk); #1;
      start = 1'b0; expo = '0; iters = '0;
      total++;
      if (err !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
        bad++;
        $display("FAIL err_pulse[%0d]: err=%b busy=%b valid=%b, required 1 0 0", t, err, busy, valid);
      end
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        total++;
        if (err !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
          bad++;
          $display("FAIL err_after[%0d]: err=%b valid=%b busy=%b, required 0 0 0", t, err, valid, busy);
        end
      end
    end
  endtask

  task automatic test_stall();
    ready_mode = 2;
    run_seq(EB'(8'h0B), 1, 200, 0);
    run_seq(EB'(8'h0B), 2, 400, 0);
    ready_mode = 1;
  endtask

  task automatic test_pasta();
    logic [255:0]  wide;
    logic [EB-1:0] pe;
    int            msb = -1;
    wide = 256'h33333333333333333333333333333333333333333333333333333333cccccccd;
    pe   = wide[EB-1:0];
    for (int i = 0; i < EB; i++) if (pe[i]) msb = i;
    ready_mode = 1;
    run_seq(pe, 3, 3000, 0);
    total++;
    if (hs_count != 3 * (msb + $countones(pe) - 1)) begin
      bad++;
      $display("FAIL pasta_count: handshakes=%0d, required %0d", hs_count,
               3 * (msb + $countones(pe) - 1));
    end
  endtask

  task automatic test_start_while_busy();
    ready_mode = 1;
    run_seq(EB'(8'h0B), 2, 80, 1);
  endtask

  task automatic test_abort();
    bit found = 0;
    ready_mode = 1;
    @(posedge clk); #1;
    start = 1'b1; expo = EB'(8'h0B); iters = IB'(1);
    @(posedge clk); #1;
    start = 1'b0; expo = '0; iters = '0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (valid === 1'b1 && op === Mul) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL abort_reach_mul: no Mul command within 20 cycles, required one");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("abort_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    run_seq(EB'(8'h0B), 1, 50, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_two_iters();
    test_errors();
    test_stall();
    test_pasta();
    test_start_while_busy();
    test_abort();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
